ddr2_if_local_cmd_adapter: RTL

DDR2_IF_LOCAL_CMD_ADAPTER -- requirements
Module: ddr2_if_local_cmd_adapter

---
 rtl/ddr2_if_local_cmd_adapter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ddr2_if_local_cmd_adapter.sv
// Client command adapter for a DDR2 controller local interface: one request in flight,
// write data staged in a small FIFO for the controller to pull, read responses forwarded.
module ddr2_if_local_cmd_adapter #(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 128,
  parameter int BE_W       = 16,
  parameter int WBUF_DEPTH = 4,
  parameter int MAX_RD     = 8
) (
  input  logic              phy_clk,
  input  logic              reset_phy_clk_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [BE_W-1:0]   cmd_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              err_underflow,
  output logic              err_unexpected_rd,
  input  logic              local_init_done,
  input  logic              local_ready,
  output logic              local_write_req,
  output logic              local_read_req,
  output logic              local_burstbegin,
  output logic              local_size,
  output logic [ADDR_W-1:0] local_address,
  input  logic              local_wdata_req,
  output logic [DATA_W-1:0] local_wdata,
  output logic [BE_W-1:0]   local_be,
  input  logic              local_rdata_valid,
  input  logic [DATA_W-1:0] local_rdata,
  output logic [1:0]        dbg_state
);

  // Handshakes: a command transfers on a cycle with cmd_valid & cmd_ready; a controller
  // request transfers on a REQ cycle with local_ready; rsp_valid is a one-cycle pulse with
  // no backpressure.

  localparam int PTR_W = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int RC_W  = $clog2(MAX_RD + 1);

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_REQ  = 2'd2;

  localparam logic [CNT_W-1:0] WBUF_FULL = CNT_W'(WBUF_DEPTH);
  localparam logic [RC_W-1:0]  RD_LIMIT  = RC_W'(MAX_RD);

  logic [1:0]        r_state;
  logic              r_first;
  logic              r_is_write;
  logic [ADDR_W-1:0] r_addr;

  logic [DATA_W-1:0] r_mem_data [WBUF_DEPTH];
  logic [BE_W-1:0]   r_mem_be   [WBUF_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_wcount;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;

  logic [RC_W-1:0]   r_rd_count;
  logic              r_err_uf;
  logic              r_err_ur;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;

  logic w_pop;
  logic w_wbuf_room;
  logic w_rd_room;
  logic w_cmd_ready;
  logic w_accept;
  logic w_push;
  logic w_rd_issue;
  logic w_rd_ret;

  // A full buffer still takes a write when the controller pops in the same cycle.
  assign w_pop       = local_wdata_req && (r_wcount != '0);
  assign w_wbuf_room = (r_wcount != WBUF_FULL) || w_pop;
  assign w_rd_room   = (r_rd_count < RD_LIMIT);
  assign w_cmd_ready = (r_state == S_IDLE) && local_init_done &&
                       (cmd_write ? w_wbuf_room : w_rd_room);
  assign w_accept    = cmd_valid && w_cmd_ready;
  assign w_push      = w_accept && cmd_write;
  assign w_rd_issue  = (r_state == S_REQ) && !r_is_write && local_ready && local_init_done;
  assign w_rd_ret    = local_rdata_valid && (r_rd_count != '0);

  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      r_state    <= S_INIT;
      r_first    <= 1'b0;
      r_is_write <= 1'b0;
      r_addr     <= '0;
    end else begin
      r_first <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (local_init_done) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (!local_init_done) begin
            r_state <= S_INIT;
          end else if (w_accept) begin
            r_state    <= S_REQ;
            r_first    <= 1'b1;
            r_is_write <= cmd_write;
            r_addr     <= cmd_addr;
          end
        end
        S_REQ: begin
          // Losing calibration drops the pending request outright.
          if (!local_init_done)  r_state <= S_INIT;
          else if (local_ready)  r_state <= S_IDLE;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge phy_clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= cmd_wdata;
      r_mem_be[r_wr_ptr]   <= cmd_be;
    end
  end

  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_wcount <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_err_uf <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_wdata  <= r_mem_data[r_rd_ptr];
        r_be     <= r_mem_be[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_wcount <= r_wcount + CNT_W'(1);
        2'b01:   r_wcount <= r_wcount - CNT_W'(1);
        default: r_wcount <= r_wcount;
      endcase
      if (local_wdata_req && (r_wcount == '0)) r_err_uf <= 1'b1;
    end
  end

  always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
    if (!reset_phy_clk_n) begin
      r_rd_count  <= '0;
      r_err_ur    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      case ({w_rd_issue, w_rd_ret})
        2'b10:   r_rd_count <= r_rd_count + RC_W'(1);
        2'b01:   r_rd_count <= r_rd_count - RC_W'(1);
        default: r_rd_count <= r_rd_count;
      endcase
      // Stray read data is flagged but still forwarded to the client.
      if (local_rdata_valid && (r_rd_count == '0)) r_err_ur <= 1'b1;
      r_rsp_valid <= local_rdata_valid;
      r_rsp_data  <= local_rdata;
    end
  end

  assign cmd_ready         = w_cmd_ready;
  assign local_write_req   = (r_state == S_REQ) && r_is_write;
  assign local_read_req    = (r_state == S_REQ) && !r_is_write;
  assign local_burstbegin  = (r_state == S_REQ) && r_first;
  assign local_size        = 1'b1;
  assign local_address     = r_addr;
  assign local_wdata       = r_wdata;
  assign local_be          = r_be;
  assign rsp_valid         = r_rsp_valid;
  assign rsp_data          = r_rsp_data;
  assign err_underflow     = r_err_uf;
  assign err_unexpected_rd = r_err_ur;
  assign dbg_state         = r_state;

endmodule
